// File: rtl/ram_sequencer.sv
// rtl/ram_sequencer.sv - command sequencer for the 16x8 register-file RAM (write/read/fill/verify).
// Optional RAM_SEQ_PATTERN_EN: incrementing fill/verify pattern instead of a constant one.
module ram_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_VERIFY = 2'b11;
  localparam int         CW        = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_FILL,
    S_VER,
    S_FIN
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   remaining, remaining_n;
  logic [DATA_W-1:0]   pattern, pattern_n;
  logic                cmd_ready_n, rsp_valid_n, done_n, ram_write_n, ram_read_n;
  logic [DATA_W-1:0]   rsp_data_n, ram_wdata_n;
  logic [ADDR_W:0]     err_count_n;
  logic [ADDR_W-1:0]   first_err_addr_n, ram_addr_n;
  logic [DATA_W-1:0]   wdata_step, pattern_step;
  logic                accept;

  // Next word of the fill data and of the verify expectation.
`ifdef RAM_SEQ_PATTERN_EN
  assign wdata_step   = ram_wdata + DATA_W'(1);
  assign pattern_step = pattern + DATA_W'(1);
`else
  assign wdata_step   = ram_wdata;
  assign pattern_step = pattern;
`endif

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      remaining      <= '0;
      pattern        <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      done           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_write      <= 1'b0;
      ram_read       <= 1'b0;
    end else begin
      state          <= state_n;
      remaining      <= remaining_n;
      pattern        <= pattern_n;
      cmd_ready      <= cmd_ready_n;
      rsp_valid      <= rsp_valid_n;
      rsp_data       <= rsp_data_n;
      done           <= done_n;
      err_count      <= err_count_n;
      first_err_addr <= first_err_addr_n;
      ram_addr       <= ram_addr_n;
      ram_wdata      <= ram_wdata_n;
      ram_write      <= ram_write_n;
      ram_read       <= ram_read_n;
    end
  end

  always_comb begin
    state_n          = state;
    remaining_n      = remaining;
    pattern_n        = pattern;
    cmd_ready_n      = 1'b0;
    rsp_valid_n      = 1'b0;
    rsp_data_n       = rsp_data;
    done_n           = 1'b0;
    err_count_n      = err_count;
    first_err_addr_n = first_err_addr;
    ram_addr_n       = ram_addr;
    ram_wdata_n      = ram_wdata;
    ram_write_n      = 1'b0;
    ram_read_n       = 1'b0;

    case (state)
      S_IDLE, S_FIN: begin
        state_n     = S_IDLE;
        cmd_ready_n = 1'b1;
        if (accept) begin
          cmd_ready_n = 1'b0;
          ram_addr_n  = cmd_addr;
          remaining_n = cmd_len;
          pattern_n   = cmd_data;
          case (cmd_op)
            OP_WRITE: begin
              state_n     = S_WR;
              ram_write_n = 1'b1;
              ram_wdata_n = cmd_data;
            end
            OP_READ: begin
              state_n    = S_RD;
              ram_read_n = 1'b1;
            end
            OP_FILL: begin
              state_n     = S_FILL;
              ram_write_n = 1'b1;
              ram_wdata_n = cmd_data;
            end
            OP_VERIFY: begin
              state_n          = S_VER;
              ram_read_n       = 1'b1;
              err_count_n      = '0;
              first_err_addr_n = '0;
            end
            default: state_n = S_IDLE;
          endcase
        end
      end

      S_WR: begin
        state_n     = S_FIN;
        done_n      = 1'b1;
        cmd_ready_n = 1'b1;
      end

      S_RD: begin
        state_n     = S_FIN;
        rsp_data_n  = ram_rdata;
        rsp_valid_n = 1'b1;
        done_n      = 1'b1;
        cmd_ready_n = 1'b1;
      end

      S_FILL: begin
        if (remaining == '0) begin
          state_n     = S_FIN;
          done_n      = 1'b1;
          cmd_ready_n = 1'b1;
        end else begin
          ram_write_n = 1'b1;
          ram_addr_n  = ram_addr + ADDR_W'(1);
          ram_wdata_n = wdata_step;
          remaining_n = remaining - ADDR_W'(1);
        end
      end

      S_VER: begin
        // The word on ram_rdata belongs to the address driven this cycle.
        if (ram_rdata != pattern) begin
          err_count_n = err_count + CW'(1);
          if (err_count == '0) first_err_addr_n = ram_addr;
        end
        if (remaining == '0) begin
          state_n     = S_FIN;
          done_n      = 1'b1;
          cmd_ready_n = 1'b1;
        end else begin
          ram_read_n  = 1'b1;
          ram_addr_n  = ram_addr + ADDR_W'(1);
          pattern_n   = pattern_step;
          remaining_n = remaining - ADDR_W'(1);
        end
      end

      default: begin
        state_n     = S_IDLE;
        cmd_ready_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_sequencer.sv
// tb/tb_ram_sequencer.sv - randomized self-checking bench for ram_sequencer with an array RAM model.
module tb_ram_sequencer;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_FILL   = 2'b10;
  localparam logic [1:0] OP_VERIFY = 2'b11;
`ifdef RAM_SEQ_PATTERN_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] cmd_data;
  logic       rsp_valid, done;
  logic [7:0] rsp_data;
  logic [4:0] err_count;
  logic [3:0] first_err_addr, ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       ram_write, ram_read;

  always #5 clk = ~clk;

  ram_sequencer #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write(ram_write),
    .ram_read(ram_read), .ram_rdata(ram_rdata)
  );

  // The RAM itself: combinational read, write on the clock edge.
  logic [7:0] ram [16];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_write) ram[ram_addr] <= ram_wdata;

  // Reference state: expected memory contents and verify results.
  logic [7:0] mdl [16];
  int m_err, m_first;
  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [7:0] seed, input int i);
    return seed + 8'(i * INC);
  endfunction

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_ctl", {ram_write, ram_read, done, cmd_ready, rsp_valid}, 5'b00010);
    end
  endtask

  // Issue one command at a negedge and check every cycle until its FIN cycle.
  task automatic run_cmd(input logic [1:0] op, input int a, input int len,
                         input logic [7:0] d, input bit hold);
    int L, errs, first, ea;
    bit acc, wr, rd, dn;
    logic [7:0] exp_rd, ewd;
    L = (op == OP_WRITE || op == OP_READ) ? 1 : len + 1;
    cmd_op = op; cmd_addr = a[3:0]; cmd_len = len[3:0]; cmd_data = d; cmd_valid = 1'b1;
    check("ready_at_issue", cmd_ready, 1);
    exp_rd = mdl[a % 16];
    if (op == OP_VERIFY) begin
      errs = 0; first = 0;
      for (int i = 0; i < L; i++)
        if (mdl[(a + i) % 16] != pat(d, i)) begin
          if (errs == 0) first = (a + i) % 16;
          errs++;
        end
      m_err = errs; m_first = first;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_op = 2'($urandom); cmd_addr = 4'($urandom);
      cmd_len = 4'($urandom); cmd_data = 8'($urandom);
    end else cmd_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      acc = (k <= L);
      wr  = acc && (op == OP_WRITE || op == OP_FILL);
      rd  = acc && (op == OP_READ || op == OP_VERIFY);
      dn  = !acc;
      check("ctl", {ram_write, ram_read, done, cmd_ready, rsp_valid},
            {wr, rd, dn, dn, dn && (op == OP_READ)});
      if (acc) begin
        ea = (a + k - 1) % 16;
        check("addr", ram_addr, ea);
        if (wr) begin
          ewd = (op == OP_WRITE) ? d : pat(d, k - 1);
          check("wdata", ram_wdata, ewd);
          mdl[ea] = ewd;
        end
      end else begin
        check("addr_hold", ram_addr, (a + L - 1) % 16);
        if (op == OP_READ) check("rsp_data", rsp_data, exp_rd);
        check("err_count", err_count, m_err);
        check("first_err_addr", first_err_addr, m_first);
      end
    end
  endtask

  logic [1:0] r_op;
  int r_a, r_len, fl_a, fl_len;
  logic [7:0] r_d, fl_d;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'h00;
      mdl[i] = 8'h00;
    end
    m_err = 0; m_first = 0;
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_addr = 4'h0; cmd_len = 4'h0; cmd_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ctl", {ram_write, ram_read, done, cmd_ready, rsp_valid}, 5'b00010);
    check("rst_addr", ram_addr, 0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_err", {err_count, first_err_addr}, 0);
    reset = 1'b1;
    @(negedge clk);

    // write then read back
    run_cmd(OP_WRITE, 3, 0, 8'hA5, 0);
    run_cmd(OP_READ, 3, 0, 8'h00, 0);
    check("t1_rsp", rsp_data, 8'hA5);

    // wrapping fill and clean verify
    idle(1);
    run_cmd(OP_FILL, 14, 3, 8'h10, 0);
    run_cmd(OP_VERIFY, 14, 3, 8'h10, 0);
    check("t2_err", err_count, 0);

    // one corrupted word inside the range
    run_cmd(OP_WRITE, 0, 0, 8'hFF, 0);
    run_cmd(OP_VERIFY, 14, 3, 8'h10, 0);
    check("t3_err", err_count, 1);
    check("t3_first", first_err_addr, 0);

    // full-block fill
    run_cmd(OP_FILL, 0, 15, 8'hF0, 0);
    run_cmd(OP_READ, 1, 0, 8'h00, 0);
    check("t4_rsp", rsp_data, pat(8'hF0, 1));
    run_cmd(OP_VERIFY, 0, 15, 8'hF0, 0);
    check("t4_err", err_count, 0);

    // commands held during a busy fill, then taken back-to-back in FIN
    run_cmd(OP_FILL, 5, 9, 8'h77, 1);
    run_cmd(OP_READ, 7, 0, 8'h00, 1);
    run_cmd(OP_VERIFY, 5, 9, 8'h77, 0);

    // reset in cycle 2 of a 16-word fill
    idle(1);
    cmd_op = OP_FILL; cmd_addr = 4'd9; cmd_len = 4'd15; cmd_data = 8'h3C; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    mdl[9] = 8'h3C;
    #2 reset = 1'b0;
    #1;
    check("t5_ctl", {ram_write, ram_read, done, cmd_ready, rsp_valid}, 5'b00010);
    check("t5_err", err_count, 0);
    m_err = 0; m_first = 0;
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    run_cmd(OP_READ, 9, 0, 8'h00, 0);
    run_cmd(OP_READ, 10, 0, 8'h00, 0);

    // randomized traffic
    fl_a = 0; fl_len = 15; fl_d = 8'hF0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      r_op  = 2'($urandom);
      r_a   = $urandom_range(0, 15);
      r_len = $urandom_range(0, 15);
      r_d   = 8'($urandom);
      if (r_op == OP_VERIFY && $urandom_range(0, 1) == 1) begin
        r_a = fl_a; r_len = fl_len; r_d = fl_d;
      end
      if (r_op == OP_FILL) begin
        fl_a = r_a; fl_len = r_len; fl_d = r_d;
      end
      run_cmd(r_op, r_a, r_len, r_d, $urandom_range(0, 1) == 1);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
